// File: rtl/fetch.sv
// Instruction fetch front end: PC sequencing, credit-limited imem requests, in-order fetch queue, redirect flush/discard.
// Latency: first request the cycle after reset release or redirect; instruction valid 1 + memory latency cycles later.
// Backpressure: inst_rdy_i stalls the queue; requests stop once in-flight plus buffered entries reach QDEPTH.

// Small FIFO with synchronous flush; head is presented combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: the caller must never push into a full FIFO unless popping in the same cycle.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_head_dat,
    output logic [CW-1:0] o_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_pop  = i_pop && (r_cnt != '0) && !i_flush;
    assign w_push = i_push && !i_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_cnt      = r_cnt;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && !w_pop && (r_cnt == CW'(DEPTH))));
endmodule

module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_v_x,
    input  logic [31:0] pc_x,
    output logic        imem_req_v,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_rdy,
    input  logic        imem_rsp_v,
    input  logic [31:0] imem_rsp_data,
    input  logic        inst_rdy_i,
    output logic        inst_v_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);
    localparam int CW  = $clog2(QDEPTH + 1);
    localparam int CW1 = CW + 1;

    logic [31:0]   r_fpc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_disc_cnt;

    logic          w_fire;
    logic          w_deliver;
    logic          w_rsp_keep;
    logic [CW-1:0] w_q_cnt;
    logic [CW-1:0] w_pc_cnt;
    logic [CW:0]   w_credit_used;
    logic [31:0]   w_rsp_pc;
    logic [31:0]   w_redir_pc;
    logic [63:0]   w_head;

    assign w_redir_pc = pc_x & 32'hFFFF_FFFC;

    // A slot being dequeued this cycle is already free, which keeps a 1-cycle memory streaming at full rate.
    assign w_credit_used = {1'b0, r_out_cnt} + {1'b0, w_q_cnt} - CW1'(w_deliver);

    assign inst_v_o      = reset_n && (w_q_cnt != '0) && !pc_v_x;
    assign w_deliver     = inst_v_o && inst_rdy_i;
    assign imem_req_v    = reset_n && !pc_v_x && (w_credit_used < CW1'(QDEPTH));
    assign imem_req_addr = r_fpc;
    assign w_fire        = imem_req_v && imem_req_rdy;
    assign w_rsp_keep    = imem_rsp_v && (r_disc_cnt == '0) && !pc_v_x;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fpc      <= RESET_PC;
            r_out_cnt  <= '0;
            r_disc_cnt <= '0;
        end else begin
            r_out_cnt <= r_out_cnt + CW'(w_fire) - CW'(imem_rsp_v);
            if (pc_v_x) begin
                r_fpc      <= w_redir_pc;
                r_disc_cnt <= r_out_cnt - CW'(imem_rsp_v);
            end else begin
                if (w_fire) r_fpc <= r_fpc + 32'd4;
                if (imem_rsp_v && (r_disc_cnt != '0)) r_disc_cnt <= r_disc_cnt - CW'(1);
            end
        end
    end

    // PCs of live (non-discarded) requests, oldest first; lines up with returning responses.
    fetch_fifo #(.W(32), .DEPTH(QDEPTH), .CW(CW)) u_pc_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_flush    (pc_v_x),
        .i_push     (w_fire),
        .i_push_dat (r_fpc),
        .i_pop      (w_rsp_keep),
        .o_head_dat (w_rsp_pc),
        .o_cnt      (w_pc_cnt)
    );

    fetch_fifo #(.W(64), .DEPTH(QDEPTH), .CW(CW)) u_inst_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_flush    (pc_v_x),
        .i_push     (w_rsp_keep),
        .i_push_dat ({w_rsp_pc, imem_rsp_data}),
        .i_pop      (w_deliver),
        .o_head_dat (w_head),
        .o_cnt      (w_q_cnt)
    );

    assign pc_o   = w_head[63:32];
    assign inst_o = w_head[31:0];

    a_inflight_split: assert property (@(posedge clk) disable iff (!reset_n)
        ({1'b0, w_pc_cnt} + {1'b0, r_disc_cnt}) == {1'b0, r_out_cnt});
endmodule
